csa_accumulator: RTL and testbench

Streaming signed accumulator for systolic PE output columns. It keeps a running total in carry-save form, one row of full adders per accepted beat, so no carry ripples in the accumulate path. At end of packet it resolves the total with a single ripple carry-propagate add, then presents the result on a valid/ready output port. It sits between a PE column's partial-sum output and the result writeback.

---
 rtl/csa_accumulator_if.sv | 43 ++++
 rtl/csa_accumulator.sv | 122 ++++++++++++
 tb/tb_csa_accumulator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/csa_accumulator_if.sv
// Stream handshake bundle for csa_accumulator: input beats in, resolved packet sum out.
// out_count exists only when CSA_ACC_CNT_EN is defined.
interface csa_accumulator_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
`ifdef CSA_ACC_CNT_EN
  logic [15:0]      out_count;
`endif

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
`ifdef CSA_ACC_CNT_EN
    input  out_count,
`endif
    input  out_sum
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
`ifdef CSA_ACC_CNT_EN
    output out_count,
`endif
    output out_sum
  );
endinterface

// File: rtl/csa_accumulator.sv
// Signed streaming accumulator: carry-save accumulate per beat, one ripple add per packet.
// Optional 16-bit beat counter and out_count port when CSA_ACC_CNT_EN is defined.
module csa_accumulator #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  csa_accumulator_if.slave bus
);

  typedef enum logic [1:0] {StAcc, StResolve, StHold} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
`ifdef CSA_ACC_CNT_EN
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      out_count_q, out_count_d;
`endif

  logic             accept;
  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] sum_v;
  logic [ACC_W-2:0] cout_lo;

  assign accept = bus.in_valid && in_ready_q;
  assign x      = ACC_W'($signed(bus.in_data));

  // Full-adder row; the top carry-out would shift past bit ACC_W-1, so it is never formed.
  assign sum_v   = s_q ^ c_q ^ x;
  assign cout_lo = (s_q[ACC_W-2:0] & c_q[ACC_W-2:0]) | (s_q[ACC_W-2:0] & x[ACC_W-2:0]) |
                   (c_q[ACC_W-2:0] & x[ACC_W-2:0]);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
`ifdef CSA_ACC_CNT_EN
    cnt_d       = cnt_q;
    out_count_d = out_count_q;
`endif
    unique case (state_q)
      StAcc: begin
        in_ready_d = 1'b1;
        if (accept) begin
          s_d = sum_v;
          c_d = {cout_lo, 1'b0};
`ifdef CSA_ACC_CNT_EN
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
          if (bus.in_last) begin
            state_d    = StResolve;
            in_ready_d = 1'b0;
          end
        end
      end
      StResolve: begin
        out_sum_d   = s_q + c_q;
        s_d         = '0;
        c_d         = '0;
        out_valid_d = 1'b1;
        state_d     = StHold;
`ifdef CSA_ACC_CNT_EN
        out_count_d = cnt_q;
        cnt_d       = '0;
`endif
      end
      StHold: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StAcc;
        end
      end
      default: begin
        state_d    = StAcc;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAcc;
      s_q         <= '0;
      c_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
`ifdef CSA_ACC_CNT_EN
      cnt_q       <= '0;
      out_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
`ifdef CSA_ACC_CNT_EN
      cnt_q       <= cnt_d;
      out_count_q <= out_count_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
`ifdef CSA_ACC_CNT_EN
  assign bus.out_count = out_count_q;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed and random-gap bench for csa_accumulator with a packet-level sum/handshake model.
// Inputs change at posedge+2; everything is sampled on the falling edge.
module tb_csa_accumulator;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  csa_accumulator_if #(.IN_W(8), .ACC_W(16)) bus ();

  csa_accumulator #(.IN_W(8), .ACC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: signed sums mod 2^16, result queue, and expected handshake timing.
  typedef struct packed {
    logic [15:0] sum;
    logic [15:0] cnt;
  } res_t;

  res_t        q[$];
  logic [15:0] m_acc;
  logic [15:0] m_cnt;
  bit          busy;
  bit          fresh;
  int          cyc;
  int          last_cyc;

  initial begin
    m_acc = '0; m_cnt = '0; busy = 0; fresh = 1; cyc = 0; last_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_sum", {16'd0, bus.out_sum}, 32'd0);
`ifdef CSA_ACC_CNT_EN
        chk("rst_out_count", {16'd0, bus.out_count}, 32'd0);
`endif
        m_acc = '0; m_cnt = '0; busy = 0; fresh = 1;
        q.delete();
      end else begin
        chk("m_in_ready", {31'd0, bus.in_ready}, {31'd0, !busy && !fresh});
        chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, busy && (cyc >= last_cyc + 2)});
        fresh = 0;
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            chk("m_unexpected_result", 32'd1, 32'd0);
          end else begin
            chk("m_out_sum", {16'd0, bus.out_sum}, {16'd0, q[0].sum});
`ifdef CSA_ACC_CNT_EN
            chk("m_out_count", {16'd0, bus.out_count}, {16'd0, q[0].cnt});
`endif
            if (bus.out_ready) void'(q.pop_front());
          end
          if (bus.out_ready) busy = 0;
        end
        if (bus.in_valid && bus.in_ready) begin
          m_acc = m_acc + {{8{bus.in_data[7]}}, bus.in_data};
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (bus.in_last) begin
            q.push_back('{sum: m_acc, cnt: m_cnt});
            m_acc = '0; m_cnt = '0; busy = 1; last_cyc = cyc;
          end
        end
      end
    end
  end

  // Presents one beat and holds it until accepted; returns at posedge+2 after the accept.
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Waits for the result, checks it, stalls `stall` cycles, then completes the handshake.
  task automatic get_result(input string name, input logic [15:0] es, input logic [15:0] ec,
                            input int stall);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      chk({name, "_timeout"}, 32'd1, 32'd0);
    end else begin
      chk({name, "_sum"}, {16'd0, bus.out_sum}, {16'd0, es});
`ifdef CSA_ACC_CNT_EN
      chk({name, "_count"}, {16'd0, bus.out_count}, {16'd0, ec});
`else
      if (ec == 16'd0) chk({name, "_zero_len"}, 32'd1, 32'd0);
`endif
    end
    repeat (stall) begin
      @(negedge clk);
      chk({name, "_stall_ready"}, {31'd0, bus.in_ready}, 32'd0);
      chk({name, "_stall_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({name, "_stall_sum"}, {16'd0, bus.out_sum}, {16'd0, es});
    end
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] s;
    int          len;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_low", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("post_rst_ready_high", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #2;

    // Basic sum with latency pin-down.
    send(8'd3, 1'b0);
    send(8'd5, 1'b0);
    send(8'd7, 1'b1);
    @(negedge clk);
    chk("basic_lat_resolve", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("basic_lat_hold", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #2;
    get_result("basic", 16'h000F, 16'd3, 0);

    // Negatives.
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    get_result("neg", 16'hFFFD, 16'd3, 0);

    // Single beat, most negative operand.
    send(8'h80, 1'b1);
    get_result("single", 16'hFF80, 16'd1, 0);

    // Wrap: 520 * 127 = 66040 -> 504.
    for (int i = 0; i < 520; i++) send(8'h7F, i == 519);
    get_result("wrap", 16'h01F8, 16'd520, 0);

    // Backpressure with a held next beat.
    send(8'd10, 1'b0);
    send(8'd20, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd5;
    bus.in_last  = 1'b1;
    get_result("bp", 16'h001E, 16'd2, 5);
    @(negedge clk);
    chk("bp_ready_after", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    get_result("bp_held", 16'h0005, 16'd1, 0);

    // Asynchronous reset mid-packet discards the partial sum.
    send(8'd100, 1'b0);
    send(8'd100, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    get_result("midrst", 16'h0003, 16'd2, 0);

    // Random lengths and gaps.
    for (int p = 0; p < 3; p++) begin
      len = $urandom_range(1, 40);
      s   = '0;
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #2;
        end
        d = 8'($urandom);
        s = s + {{8{d[7]}}, d};
        send(d, i == len - 1);
      end
      get_result("rand", s, 16'(len), $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
